// File: rtl/mem_access_unit.sv
// Load/store unit for a word-addressed data memory: lane extraction with sign or
// zero extension on loads, read-modify-write for sub-word stores, misalignment faults.
module mem_access_unit #(
   parameter bit FAULT_ON_MISALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

   localparam logic [2:0] OP_SB = 3'b011;
   localparam logic [2:0] OP_SH = 3'b110;
   localparam logic [2:0] OP_SW = 3'b111;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q, word_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;

   function automatic logic is_store(input logic [2:0] o);
      return (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
   endfunction

   function automatic logic [1:0] acc_size(input logic [2:0] o);
      case (o)
         3'b000, 3'b011, 3'b100: return SZ_BYTE;
         3'b001, 3'b101, 3'b110: return SZ_HALF;
         default:                return SZ_WORD;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] o, input logic [1:0] a);
      case (acc_size(o))
         SZ_HALF: return a[0];
         SZ_WORD: return |a;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] align_addr(input logic [2:0] o, input logic [31:0] a);
      case (acc_size(o))
         SZ_HALF: return {a[31:1], 1'b0};
         SZ_WORD: return {a[31:2], 2'b00};
         default: return a;
      endcase
   endfunction

   // op[2] clear selects sign extension (LB/LH); LW is full width either way
   function automatic logic [31:0] ld_extract(input logic [2:0] o, input logic [1:0] a,
                                              input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = w[{a[1], 4'b0000} +: 16];
      case (acc_size(o))
         SZ_BYTE: return o[2] ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_HALF: return o[2] ? {16'd0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] st_merge(input logic [2:0] o, input logic [1:0] a,
                                            input logic [31:0] w, input logic [31:0] d);
      logic [31:0] m;
      m = w;
      case (acc_size(o))
         SZ_BYTE: m[{a, 3'b000} +: 8]     = d[7:0];
         SZ_HALF: m[{a[1], 4'b0000} +: 16] = d[15:0];
         default: m = d;
      endcase
      return m;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         word_q  <= 32'd0;
         rdata_q <= 32'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               addr_d  = FAULT_ON_MISALIGN ? addr : align_addr(op, addr);
               wdata_d = wdata;
               if (FAULT_ON_MISALIGN && misaligned(op, addr[1:0])) begin
                  fault_d = 1'b1;
                  state_d = S_FIN;
               end else if (op == OP_SW) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            word_d = mem_rdata;
            if (is_store(op_q)) begin
               state_d = S_WR;
            end else begin
               rdata_d = ld_extract(op_q, addr_q[1:0], mem_rdata);
               state_d = S_FIN;
            end
         end
         S_WR: state_d = S_FIN;
         default: begin
            fault_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode straight from state so an async reset drops mem_write at once
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FIN);
   assign fault     = fault_q;
   assign rdata     = rdata_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_write = (state_q == S_WR);
   assign mem_wdata = (state_q == S_WR) ? st_merge(op_q, addr_q[1:0], word_q, wdata_q) : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one faulting instance and one aligning
// instance, each with its own negedge-write memory model.
module tb_mem_access_unit;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, SB = 3'b011;
   localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, SH = 3'b110, SW = 3'b111;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start2;
   logic [2:0]  op;
   logic [31:0] addr, wdata;

   logic        busy1, done1, fault1, mem_write1;
   logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        busy2, done2, fault2, mem_write2;
   logic [31:0] rdata2, mem_addr2, mem_wdata2, mem_rdata2;

   logic [31:0] mem1 [0:255];
   logic [31:0] mem2 [0:255];
   int          wr1 = 0, wr2 = 0, done1_cnt = 0;
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.FAULT_ON_MISALIGN(1'b1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy1), .done(done1), .fault(fault1), .rdata(rdata1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_write(mem_write1),
      .mem_rdata(mem_rdata1));

   mem_access_unit #(.FAULT_ON_MISALIGN(1'b0)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy2), .done(done2), .fault(fault2), .rdata(rdata2),
      .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_write(mem_write2),
      .mem_rdata(mem_rdata2));

   assign mem_rdata1 = mem1[mem_addr1[9:2]];
   assign mem_rdata2 = mem2[mem_addr2[9:2]];

   always @(negedge clk) begin
      if (mem_write1) begin
         mem1[mem_addr1[9:2]] = mem_wdata1;
         wr1++;
      end
      if (mem_write2) begin
         mem2[mem_addr2[9:2]] = mem_wdata2;
         wr2++;
      end
      if (done1) done1_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // Issue one request at #1 after a posedge; returns latency (0 = timeout) and the
   // fault/rdata seen during the done cycle, then steps back into IDLE.
   task automatic run(input bit which, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic f,
                      output logic [31:0] rd);
      op = o; addr = a; wdata = d;
      if (which) start2 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start2 = 1'b0;
      lat = 0; f = 1'bx; rd = 'x;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (which ? done2 : done1) begin
            lat = i;
            f  = which ? fault2 : fault1;
            rd = which ? rdata2 : rdata1;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   int          lat, wr_before, dc_before;
   logic        f;
   logic [31:0] rd;

   initial begin
      reset = 1'b1; start = 1'b0; start2 = 1'b0; op = LB; addr = '0; wdata = '0;
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 32'd0;
         mem2[i] = 32'd0;
      end
      mem1[4] = 32'h8899AABB;
      mem1[5] = 32'h11223344;
      mem2[4] = 32'h8899AABB;
      repeat (2) @(posedge clk); #1;

      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_done", {31'd0, done1}, 32'd0);
      chk("rst_fault", {31'd0, fault1}, 32'd0);
      chk("rst_mem_write", {31'd0, mem_write1}, 32'd0);
      chk("rst_rdata", rdata1, 32'd0);
      chk("rst_mem_addr", mem_addr1, 32'd0);
      chk("rst_mem_wdata", mem_wdata1, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      wr_before = wr1;
      run(0, LW, 32'h10, 32'd0, lat, f, rd);
      chk("lw_latency", lat, 2);
      chk("lw_rdata", rd, 32'h8899AABB);
      chk("lw_fault", {31'd0, f}, 32'd0);
      chk("lw_no_write", wr1 - wr_before, 0);

      run(0, LB, 32'h13, 32'd0, lat, f, rd);
      chk("lb_13", rd, 32'hFFFFFF88);
      run(0, LBU, 32'h13, 32'd0, lat, f, rd);
      chk("lbu_13", rd, 32'h00000088);
      run(0, LH, 32'h12, 32'd0, lat, f, rd);
      chk("lh_12", rd, 32'hFFFF8899);
      run(0, LHU, 32'h10, 32'd0, lat, f, rd);
      chk("lhu_10", rd, 32'h0000AABB);
      chk("lhu_latency", lat, 2);
      run(0, LB, 32'h10, 32'd0, lat, f, rd);
      chk("lb_10", rd, 32'hFFFFFFBB);

      wr_before = wr1;
      run(0, SB, 32'h11, 32'h123456CC, lat, f, rd);
      chk("sb_latency", lat, 3);
      chk("sb_one_write", wr1 - wr_before, 1);
      chk("sb_word", mem1[4], 32'h8899CCBB);
      chk("sb_rdata_kept", rdata1, 32'hFFFFFFBB);
      wr_before = wr1;
      run(0, SH, 32'h12, 32'h00007777, lat, f, rd);
      chk("sh_latency", lat, 3);
      chk("sh_one_write", wr1 - wr_before, 1);
      chk("sh_word", mem1[4], 32'h7777CCBB);

      wr_before = wr1;
      run(0, SH, 32'h11, 32'h0000DEAD, lat, f, rd);
      chk("sh_mis_latency", lat, 1);
      chk("sh_mis_fault", {31'd0, f}, 32'd1);
      chk("sh_mis_no_write", wr1 - wr_before, 0);
      chk("sh_mis_word", mem1[4], 32'h7777CCBB);
      chk("fault_cleared", {31'd0, fault1}, 32'd0);

      run(0, LW, 32'h12, 32'd0, lat, f, rd);
      chk("lw_mis_latency", lat, 1);
      chk("lw_mis_fault", {31'd0, f}, 32'd1);
      chk("lw_mis_rdata_kept", rd, 32'hFFFFFFBB);

      run(1, LW, 32'h12, 32'd0, lat, f, rd);
      chk("align_lw_latency", lat, 2);
      chk("align_lw_fault", {31'd0, f}, 32'd0);
      chk("align_lw_rdata", rd, 32'h8899AABB);
      run(1, LH, 32'h13, 32'd0, lat, f, rd);
      chk("align_lh_rdata", rd, 32'hFFFF8899);

      wr_before = wr1;
      op = SB; addr = 32'h10; wdata = 32'h000000AB; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mid_busy_before", {31'd0, busy1}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_busy_reset", {31'd0, busy1}, 32'd0);
      chk("mid_mem_write", {31'd0, mem_write1}, 32'd0);
      chk("mid_rdata_reset", rdata1, 32'd0);
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_no_write", wr1 - wr_before, 0);
      chk("mid_word", mem1[4], 32'h7777CCBB);
      run(0, LW, 32'h10, 32'd0, lat, f, rd);
      chk("post_rst_latency", lat, 2);
      chk("post_rst_rdata", rd, 32'h7777CCBB);

      dc_before = done1_cnt;
      op = LW; addr = 32'h10; start = 1'b1;
      @(posedge clk); #1;
      addr = 32'h14;
      @(posedge clk); #1;
      chk("ign_done_cycle", {31'd0, done1}, 32'd1);
      @(posedge clk); #1;
      chk("ign_idle_busy", {31'd0, busy1}, 32'd0);
      chk("ign_rdata_first", rdata1, 32'h7777CCBB);
      @(posedge clk); #1;
      start = 1'b0;
      chk("next_accepted", {31'd0, busy1}, 32'd1);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done1) begin
            lat = i;
            break;
         end
      end
      @(posedge clk); #1;
      chk("next_latency", lat, 2);
      chk("next_rdata", rdata1, 32'h11223344);
      repeat (2) @(posedge clk); #1;
      chk("done_once_each", done1_cnt - dc_before, 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit sitting directly upstream of the word-addressed data memory in the 5-cycle MIPS datapath.
- Accepts one byte, halfword or word request at a time and translates it into word-granular memory traffic:
  - loads: lane extraction plus sign or zero extension;
  - sub-word stores: read-modify-write;
  - misaligned addresses: fault detection.
- The memory has combinational read, a negedge-clocked write and word index addr[9:2].

Parameters:
- FAULT_ON_MISALIGN, 1, 1 = misaligned request faults with no memory access; 0 = low address bits below the access size are forced to zero.

Ports:
- clk  input  1  system clock, posedge-sampled
- reset  input  1  asynchronous, active-high
- start  input  1  request strobe, sampled only in IDLE
- op  input  3  000 LB, 001 LH, 010 LW, 011 SB, 100 LBU, 101 LHU, 110 SH, 111 SW
- addr  input  32  byte address
- wdata  input  32  store data, right-justified for SB/SH
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- fault  output  1  valid with done: misaligned request
- rdata  output  32  load result, held until the next load completes
- mem_addr  output  32  {addr_q[31:2], 2'b00}
- mem_wdata  output  32  word to write
- mem_write  output  1  memory write enable
- mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset (async): state=IDLE; busy, done, fault, mem_write = 0; rdata, mem_addr, mem_wdata = 0. Reset mid-operation aborts immediately. mem_write is decoded from state, so it drops asynchronously and no partial store reaches memory.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], with k = addr[1:0]. Halfword uses bits [15:0] when addr[1]=0 and bits [31:16] when addr[1]=1.
- Alignment rule: halfword requires addr[0]=0; word requires addr[1:0]=0.
- IDLE, on start: latch op, addr, wdata; then branch:
  - misaligned and FAULT_ON_MISALIGN=1 -> FIN with fault pending;
  - load or SB/SH -> RD;
  - SW -> WR.
- IDLE without start: no change.
- RD: mem_addr valid, mem_write=0. At the posedge, capture mem_rdata into a word register, then:
  - load -> FIN with rdata updated (extracted lane, sign-extended for LB/LH, zero-extended for LBU/LHU/LW);
  - SB/SH -> WR.
- WR: mem_write=1 for exactly this one cycle; memory commits at the mid-cycle negedge. Next state FIN.
  - SW: mem_wdata = wdata.
  - SB/SH: mem_wdata = captured word with the selected lane replaced by wdata[7:0] or wdata[15:0].
- FIN: done=1; fault=1 only for the misaligned path; next state IDLE. start is ignored in FIN and every non-IDLE state (no queueing). fault is cleared when leaving FIN.
- Latency from the accepting posedge to the done cycle: LW/LB/LH/LBU/LHU = 2 cycles, SW = 2, SB/SH = 3, fault = 1.
- Throughput: at most one request per latency+1 cycles; a new start is accepted the cycle after done.
- Faulted loads leave rdata unchanged. Stores never modify rdata.
- mem_addr and mem_wdata are don't-care outside RD/WR but must not toggle mem_write.
- An undefined op is impossible: all 8 encodings are legal.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LW 0x10 -> done 2 cycles after accept, rdata=0x8899AABB, fault=0, mem_write never high.
- Sub-word loads against the same word:
  - LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088;
  - LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB;
  - LB 0x10 -> 0xFFFFFFBB.
- SB 0x11 with wdata=0x123456CC -> mem_write high exactly one cycle, word becomes 0x8899CCBB, done 3 cycles after accept. Then SH 0x12 with wdata 0x00007777 -> 0x7777CCBB.
- Misaligned requests:
  - SH 0x11 -> done next cycle with fault=1, no mem_write, word unchanged;
  - LW 0x12 -> fault=1, rdata keeps its previous value;
  - with FAULT_ON_MISALIGN=0, LW 0x12 -> reads word 0x10, fault=0.
- Assert reset during RD of SB 0x10 -> busy=0 and state IDLE immediately, mem_write never asserted, memory unchanged. After release, LW 0x10 completes normally.
- Pulse start with LW 0x14 during busy and during the done cycle -> both ignored. start on the cycle after done -> accepted, and done is asserted exactly once per accepted request.
